// File: rtl/ddr_rd_stream_buffer_writer.sv
// Accepts num_beats wide read-stream beats and writes each one into the on-chip
// buffer as R narrower words, least significant first, at consecutive wrapping addresses.
module ddr_rd_stream_buffer_writer #(
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int BUF_DATA_WIDTH     = 256,
  parameter int BUF_ADDR_WIDTH     = 12,
  parameter int C_BEAT_CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BUF_ADDR_WIDTH-1:0]     base_addr,
  input  logic [C_BEAT_CNT_WIDTH-1:0]   num_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          err_tlast,
  input  logic                          rd_tvalid,
  output logic                          rd_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata,
  input  logic                          rd_tlast,
  output logic                          buf_we,
  output logic [BUF_ADDR_WIDTH-1:0]     buf_waddr,
  output logic [BUF_DATA_WIDTH-1:0]     buf_wdata
);

  localparam int R   = C_M_AXI_DATA_WIDTH / BUF_DATA_WIDTH;
  localparam int K_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(R - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, SPLIT, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [BUF_ADDR_WIDTH-1:0]     ptr_reg, ptr_next;
  logic [C_BEAT_CNT_WIDTH-1:0]   num_reg, num_next;
  logic [C_BEAT_CNT_WIDTH-1:0]   wr_cnt_reg, wr_cnt_next;
  logic [C_BEAT_CNT_WIDTH-1:0]   acc_cnt_reg, acc_cnt_next;
  logic [C_M_AXI_DATA_WIDTH-1:0] beat_reg, beat_next;
  logic [K_W-1:0]                k_reg, k_next;
  logic                          err_reg, err_next;

  logic                          last_sub;
  logic                          beats_left;
  logic                          hs;
  logic [C_BEAT_CNT_WIDTH-1:0]   wr_cnt_inc;
  logic [C_BEAT_CNT_WIDTH-1:0]   acc_cnt_inc;
  logic [BUF_DATA_WIDTH-1:0]     sub_words [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_sub
    assign sub_words[gi] = beat_reg[gi*BUF_DATA_WIDTH +: BUF_DATA_WIDTH];
  end

  assign wr_cnt_inc  = wr_cnt_reg + 1'b1;
  assign acc_cnt_inc = acc_cnt_reg + 1'b1;
  assign last_sub    = (state_reg == SPLIT) && (k_reg == K_LAST);
  // acc_cnt counts handshakes, so it also caps acceptance at num_beats
  assign beats_left  = (acc_cnt_reg != num_reg);
  assign rd_tready   = (state_reg == ACCEPT) || (last_sub && beats_left);
  assign hs          = rd_tvalid && rd_tready;

  assign buf_we    = (state_reg == SPLIT);
  assign buf_waddr = ptr_reg;
  assign buf_wdata = buf_we ? sub_words[k_reg] : '0;
  assign busy      = (state_reg == ACCEPT) || (state_reg == SPLIT);
  assign done      = (state_reg == DONE);
  assign err_tlast = err_reg;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    num_next     = num_reg;
    wr_cnt_next  = wr_cnt_reg;
    acc_cnt_next = acc_cnt_reg;
    beat_next    = beat_reg;
    k_next       = k_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          num_next     = num_beats;
          ptr_next     = base_addr;
          wr_cnt_next  = '0;
          acc_cnt_next = '0;
          err_next     = 1'b0;
          state_next   = (num_beats == '0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (hs) state_next = SPLIT;
      end
      SPLIT: begin
        ptr_next = ptr_reg + 1'b1;
        if (last_sub) begin
          k_next      = '0;
          wr_cnt_next = wr_cnt_inc;
          if (wr_cnt_inc == num_reg) state_next = DONE;
          else if (!hs)              state_next = ACCEPT;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A handshake can only occur in ACCEPT or on a final SPLIT cycle
    if (hs) begin
      beat_next    = rd_tdata;
      k_next       = '0;
      acc_cnt_next = acc_cnt_inc;
      if (rd_tlast != (acc_cnt_inc == num_reg)) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      num_reg     <= '0;
      wr_cnt_reg  <= '0;
      acc_cnt_reg <= '0;
      beat_reg    <= '0;
      k_reg       <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      num_reg     <= num_next;
      wr_cnt_reg  <= wr_cnt_next;
      acc_cnt_reg <= acc_cnt_next;
      beat_reg    <= beat_next;
      k_reg       <= k_next;
      err_reg     <= err_next;
    end
  end

endmodule

// File: tb/tb_ddr_rd_stream_buffer_writer.sv
// Directed bench for ddr_rd_stream_buffer_writer: a transfer-level model predicts
// every buffer write, busy/done/err_tlast each cycle; literal checks pin key scenarios.
module tb_ddr_rd_stream_buffer_writer;
  localparam int DW = 512;
  localparam int BW = 256;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam int R  = DW / BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_beats = '0;
  logic          busy, done, err_tlast;
  logic          rd_tvalid = 1'b0;
  logic          rd_tready;
  logic [DW-1:0] rd_tdata = '0;
  logic          rd_tlast = 1'b0;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [BW-1:0] buf_wdata;

  ddr_rd_stream_buffer_writer #(
    .C_M_AXI_DATA_WIDTH(DW), .BUF_DATA_WIDTH(BW),
    .BUF_ADDR_WIDTH(AW), .C_BEAT_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .err_tlast(err_tlast),
    .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tdata(rd_tdata),
    .rd_tlast(rd_tlast), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- transfer-level model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } wr_t;

  logic [DW-1:0] beat_mem [16];
  wr_t           exp_q [$];
  logic          m_active = 1'b0;
  logic          m_done   = 1'b0;
  logic          m_err    = 1'b0;
  int            m_nb     = 0;
  int            hs_idx   = 0;
  int            cyc      = 0;
  logic          rst_q    = 1'b0;
  int            start_cyc = 0, done_cyc = 0, last_we_cyc = 0;
  logic [AW-1:0] wlog [$];
  logic          tr_log [$];

  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    logic last_write, start_acc, hs;
    wr_t  e;
    if (rst_q) begin
      chk("rst_buf_we", buf_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_tlast, 0);
      chk("rst_tready", rd_tready, 0);
      chk("rst_waddr", buf_waddr, 0);
      chk("rst_wdata", buf_wdata, 0);
      exp_q.delete();
      m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; hs_idx = 0;
    end else begin
      tr_log.push_back(rd_tready);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("err_tlast", err_tlast, m_err);
      if (!m_active) chk("tready_when_idle", rd_tready, 0);
      last_write = 1'b0;
      if (buf_we) begin
        wlog.push_back(buf_waddr);
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          chk("waddr", buf_waddr, e.a);
          chk("wdata", buf_wdata, e.d);
          if (exp_q.size() == 0) last_write = 1'b1;
        end
      end
      if (done)  done_cyc  = cyc;
      if (start) start_cyc = cyc;
      hs        = rd_tvalid && rd_tready;
      start_acc = start && !m_active && !m_done;
      // advance the model to the next cycle
      m_done = last_write || (start_acc && num_beats == 0);
      if (hs) begin
        chk("beat_within_count", hs_idx < m_nb, 1);
        if (rd_tlast != (hs_idx == m_nb - 1)) m_err = 1'b1;
        hs_idx++;
      end
      if (last_write) m_active = 1'b0;
      if (start_acc) begin
        m_err = 1'b0; m_nb = int'(num_beats); hs_idx = 0;
        m_active = (num_beats != 0);
        for (int i = 0; i < int'(num_beats); i++)
          for (int k = 0; k < R; k++)
            exp_q.push_back({base_addr + AW'(i*R + k), beat_mem[i][k*BW +: BW]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill_beats(input int nb);
    for (int i = 0; i < nb; i++)
      for (int w = 0; w < DW/32; w++)
        beat_mem[i][w*32 +: 32] = $urandom;
  endtask

  task automatic xfer(input logic [AW-1:0] base, input int nb, input int gap,
                      input int bad_idx, input bit extra_start);
    int  n;
    bit  got;
    fill_beats(nb);
    base_addr = base; num_beats = CW'(nb); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~base; num_beats = CW'(nb + 5);
    for (int i = 0; i < nb; i++) begin
      rd_tvalid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (extra_start && i == 1 && g == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      rd_tvalid = 1'b1; rd_tdata = beat_mem[i];
      rd_tlast  = (i == nb - 1) ^ (i == bad_idx);
      n = 0; got = 1'b0;
      while (!got && n < 64) begin
        @(negedge clk); got = rd_tready;
        @(posedge clk); #1; n++;
      end
      if (!got) fail_now("handshake_timeout");
    end
    rd_tvalid = 1'b0; rd_tlast = 1'b0;
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n == 64) fail_now("done_timeout");
    @(posedge clk); #1;
    chk("writes_drained", exp_q.size(), 0);
  endtask

  logic [AW-1:0] s39_addr [6] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h014, 12'h015};
  logic          s39_rdy  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [AW-1:0] s40_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  initial begin
    int  hs_n, wr_n;
    logic any_rdy;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // three beats, valid held, tlast on the last
    wlog.delete(); tr_log.delete();
    xfer(12'h010, 3, 0, -1, 1'b0);
    chk("s39_nwrites", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) chk($sformatf("s39_addr%0d", i), wlog[i], s39_addr[i]);
    chk("s39_tr_len_ok", tr_log.size() >= 8, 1);
    for (int i = 0; i < 7 && i + 1 < tr_log.size(); i++) chk($sformatf("s39_tready%0d", i), tr_log[i+1], s39_rdy[i]);
    chk("s39_done_after_last_we", done_cyc - last_we_cyc, 1);
    chk("s39_err", err_tlast, 0);

    // address wrap
    wlog.delete();
    xfer(12'hFFE, 2, 0, -1, 1'b0);
    chk("s40_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk($sformatf("s40_addr%0d", i), wlog[i], s40_addr[i]);

    // zero beats
    wlog.delete(); tr_log.delete();
    xfer(12'h123, 0, 0, -1, 1'b0);
    chk("s41_nwrites", wlog.size(), 0);
    chk("s41_done_latency", done_cyc - start_cyc, 1);
    any_rdy = 1'b0;
    foreach (tr_log[i]) any_rdy |= tr_log[i];
    chk("s41_tready_low", any_rdy, 0);

    // early tlast, then a clean transfer clears the flag
    wlog.delete();
    xfer(12'h100, 2, 0, 0, 1'b0);
    chk("s42_err_set", err_tlast, 1);
    chk("s42_nwrites", wlog.size(), 4);
    xfer(12'h200, 2, 1, -1, 1'b0);
    chk("s42_err_cleared", err_tlast, 0);

    // missing tlast on the final beat
    xfer(12'h250, 1, 0, 0, 1'b0);
    chk("s42b_err_set", err_tlast, 1);

    // gapped valid with an ignored start while busy
    wlog.delete();
    xfer(12'h300, 3, 3, -1, 1'b1);
    chk("s43_nwrites", wlog.size(), 6);
    if (wlog.size() == 6) chk("s43_last_addr", wlog[5], 12'h305);

    // reset on the second split cycle of beat 2
    fill_beats(4);
    base_addr = 12'h400; num_beats = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rd_tvalid = 1'b1; rd_tdata = beat_mem[0]; rd_tlast = 1'b0;
    hs_n = 0; wr_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rd_tready) hs_n++;
      if (buf_we) wr_n++;
      if (wr_n == 4) break;
      @(posedge clk); #1;
      rd_tdata = beat_mem[hs_n]; rd_tlast = (hs_n == 2);
    end
    if (wr_n != 4) fail_now("s44_reach_beat2");
    #1 reset = 1'b1; rd_tvalid = 1'b0;
    @(negedge clk);
    chk("s44_we_after_reset", buf_we, 0);
    chk("s44_busy_after_reset", busy, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    wlog.delete();
    xfer(12'h500, 2, 0, -1, 1'b0);
    chk("s44_recovery_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) chk("s44_recovery_addr", wlog[3], 12'h503);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
